// File: rtl/lane_stream_packer.sv
// Packs a valid/ready stream of 12-bit lanes into 96-bit words for the lane shifter,
// adding pad lanes to short packets so the emitted shift never exceeds MAX_SHIFT.
module lane_stream_packer #(
    parameter int LANE_W    = 12,
    parameter int LANES     = 8,
    parameter int SHIFT_W   = 3,
    parameter int MAX_SHIFT = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANE_W-1:0]         s_lane,
    input  logic                      s_last,
    input  logic [LANE_W-1:0]         s_pad,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANE_W*LANES-1:0]   m_word,
    output logic [SHIFT_W-1:0]        m_shift,
    output logic [LANE_W-1:0]         m_fill,
    output logic [3:0]                m_lanes,
    output logic [1:0]                fsm_state
);

    localparam int WORD_W = LANE_W * LANES;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [CNT_W-1:0]   LANES_C    = CNT_W'(LANES);
    // Fewest lanes a word may carry before the shift would exceed MAX_SHIFT.
    localparam logic [CNT_W-1:0]   MIN_SPAN   = CNT_W'(LANES - MAX_SHIFT);
    localparam logic [SHIFT_W-1:0] MAX_SHIFT_C = SHIFT_W'(MAX_SHIFT);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a source holds its payload stable until that edge.

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  word;
    logic [LANE_W-1:0]  pad_q;
    logic [CNT_W-1:0]   lanes_q;
    logic [SHIFT_W-1:0] shift_q;

    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   short_shift;

    assign cnt_inc     = cnt + 1'b1;
    assign short_shift = LANES_C - cnt_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_FILL;
            cnt     <= '0;
            word    <= '0;
            pad_q   <= '0;
            lanes_q <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (s_valid) begin
                        word <= {word[WORD_W-LANE_W-1:0], s_lane};
                        cnt  <= cnt_inc;
                        if (s_last) begin
                            pad_q <= s_pad;
                        end
                        if (cnt_inc == LANES_C) begin
                            state   <= ST_HOLD;
                            shift_q <= '0;
                            lanes_q <= cnt_inc;
                        end else if (s_last && cnt_inc >= MIN_SPAN) begin
                            state   <= ST_HOLD;
                            shift_q <= short_shift[SHIFT_W-1:0];
                            lanes_q <= cnt_inc;
                        end else if (s_last) begin
                            state   <= ST_PAD;
                            lanes_q <= cnt_inc;
                        end
                    end
                end
                ST_PAD: begin
                    // Pad lanes equal the fill, so the shifter result matches a full left-align.
                    word <= {word[WORD_W-LANE_W-1:0], pad_q};
                    cnt  <= cnt_inc;
                    if (cnt_inc == MIN_SPAN) begin
                        state   <= ST_HOLD;
                        shift_q <= MAX_SHIFT_C;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        state   <= ST_FILL;
                        cnt     <= '0;
                        word    <= '0;
                        lanes_q <= '0;
                        shift_q <= '0;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

    assign s_ready   = (state == ST_FILL);
    assign m_valid   = (state == ST_HOLD);
    assign m_word    = word;
    assign m_shift   = shift_q;
    assign m_fill    = pad_q;
    assign m_lanes   = lanes_q;
    assign fsm_state = state;

endmodule
